// File: rtl/cache_ctrl_dm.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// One 32-bit word per line. Tags, data and valid bits are held in flops.
// The CPU side uses a four-phase level handshake; the memory side uses req/ack.
module cache_ctrl_dm #(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             c_clk,
  input  logic             nReset,
  input  logic [15:0]      c_addr,
  input  logic [31:0]      c_wdata,
  input  logic [3:0]       c_bval,
  input  logic             c_rd,
  input  logic             c_wr,
  output logic [31:0]      c_rdata,
  output logic             c_ack,
  output logic [15:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_bval,
  output logic             mem_rd,
  output logic             mem_wr,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int unsigned LINES = 2 ** INDEX_BITS;
  localparam int unsigned TAG_W = 14 - INDEX_BITS;

  typedef enum logic [2:0] {StIdle, StLookup, StMemRd, StMemWr, StAck} state_e;

  state_e                  state_q, state_d;
  logic [15:2]             addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [3:0]              bval_q, bval_d;
  logic                    op_rd_q, op_rd_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    ack_q, ack_d;
  logic [15:0]             mem_addr_q, mem_addr_d;
  logic [31:0]             mem_wdata_q, mem_wdata_d;
  logic [3:0]              mem_bval_q, mem_bval_d;
  logic                    mem_rd_q, mem_rd_d;
  logic                    mem_wr_q, mem_wr_d;
  logic [CNT_W-1:0]        hit_q, hit_d;
  logic [CNT_W-1:0]        miss_q, miss_d;

  logic [LINES-1:0]        valid_q;
  logic [TAG_W-1:0]        tag_q  [LINES];
  logic [31:0]             data_q [LINES];

  logic [INDEX_BITS-1:0]   idx;
  logic [TAG_W-1:0]        tag;
  logic                    hit;
  logic                    line_we;
  logic                    line_fill;
  logic [31:0]             line_wdata;

  // Byte offset bits carry no information for a word-aligned cache.
  logic                    unused_addr_bits;
  assign unused_addr_bits = ^c_addr[1:0];

  assign idx = addr_q[2 +: INDEX_BITS];
  assign tag = addr_q[15 -: TAG_W];
  assign hit = valid_q[idx] && (tag_q[idx] == tag);

  assign c_rdata   = rdata_q;
  assign c_ack     = ack_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_bval  = mem_bval_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign hit_cnt   = hit_q;
  assign miss_cnt  = miss_q;

  // Next-state, registered-output and array-update decode.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    bval_d      = bval_q;
    op_rd_d     = op_rd_q;
    rdata_d     = rdata_q;
    ack_d       = ack_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_bval_d  = mem_bval_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    hit_d       = hit_q;
    miss_d      = miss_q;
    line_we     = 1'b0;
    line_fill   = 1'b0;
    line_wdata  = data_q[idx];

    unique case (state_q)
      StIdle: begin
        if (c_rd || c_wr) begin
          addr_d  = c_addr[15:2];
          wdata_d = c_wdata;
          bval_d  = c_bval;
          // Simultaneous rd and wr is served as a read; the write is dropped.
          op_rd_d = c_rd;
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (op_rd_q) begin
          if (hit) begin
            rdata_d = data_q[idx];
            if (hit_q != {CNT_W{1'b1}}) hit_d = hit_q + CNT_W'(1);
            ack_d   = 1'b1;
            state_d = StAck;
          end else begin
            if (miss_q != {CNT_W{1'b1}}) miss_d = miss_q + CNT_W'(1);
            mem_rd_d   = 1'b1;
            mem_addr_d = {addr_q, 2'b00};
            mem_bval_d = 4'hF;
            state_d    = StMemRd;
          end
        end else if (bval_q != 4'h0) begin
          // Write-through: update the line only if already present.
          if (hit) begin
            line_we = 1'b1;
            for (int b = 0; b < 4; b++) begin
              if (bval_q[b]) line_wdata[8*b +: 8] = wdata_q[8*b +: 8];
            end
          end
          mem_wr_d    = 1'b1;
          mem_addr_d  = {addr_q, 2'b00};
          mem_wdata_d = wdata_q;
          mem_bval_d  = bval_q;
          state_d     = StMemWr;
        end else begin
          ack_d   = 1'b1;
          state_d = StAck;
        end
      end
      StMemRd: begin
        if (mem_ack) begin
          line_we    = 1'b1;
          line_fill  = 1'b1;
          line_wdata = mem_rdata;
          rdata_d    = mem_rdata;
          mem_rd_d   = 1'b0;
          ack_d      = 1'b1;
          state_d    = StAck;
        end
      end
      StMemWr: begin
        if (mem_ack) begin
          mem_wr_d = 1'b0;
          ack_d    = 1'b1;
          state_d  = StAck;
        end
      end
      StAck: begin
        if (!c_rd && !c_wr) begin
          ack_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state, registered outputs and valid bits.
  always_ff @(posedge c_clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      bval_q      <= '0;
      op_rd_q     <= 1'b0;
      rdata_q     <= '0;
      ack_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_bval_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      hit_q       <= '0;
      miss_q      <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      bval_q      <= bval_d;
      op_rd_q     <= op_rd_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_bval_q  <= mem_bval_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      if (line_fill) valid_q[idx] <= 1'b1;
    end
  end

  // Tag and data arrays; contents are meaningless until the valid bit is set.
  always_ff @(posedge c_clk) begin
    if (line_fill) tag_q[idx] <= tag;
    if (line_we) data_q[idx] <= line_wdata;
  end

endmodule

// File: tb/tb_cache_ctrl_dm.sv
// Self-checking bench for cache_ctrl_dm: directed vector table plus sequences
// for ack hold, reset during a memory read and counter saturation.
module tb_cache_ctrl_dm;

  logic        c_clk = 1'b0;
  logic        nReset = 1'b0;
  logic [15:0] c_addr = '0;
  logic [31:0] c_wdata = '0;
  logic [3:0]  c_bval = '0;
  logic        c_rd = 1'b0;
  logic        c_wr = 1'b0;
  logic [31:0] c_rdata;
  logic        c_ack;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_bval;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  // Narrow-counter twin sharing the same stimulus, used for saturation checks.
  logic [31:0] s_rdata;
  logic        s_ack;
  logic [15:0] s_mem_addr;
  logic [31:0] s_mem_wdata;
  logic [3:0]  s_mem_bval;
  logic        s_mem_rd;
  logic        s_mem_wr;
  logic [1:0]  s_hit;
  logic [1:0]  s_miss;

  always #5 c_clk = ~c_clk;

  cache_ctrl_dm #(.INDEX_BITS(4), .CNT_W(16)) dut (
    .c_clk(c_clk), .nReset(nReset), .c_addr(c_addr), .c_wdata(c_wdata), .c_bval(c_bval),
    .c_rd(c_rd), .c_wr(c_wr), .c_rdata(c_rdata), .c_ack(c_ack), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_bval(mem_bval), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  cache_ctrl_dm #(.INDEX_BITS(4), .CNT_W(2)) dut_sat (
    .c_clk(c_clk), .nReset(nReset), .c_addr(c_addr), .c_wdata(c_wdata), .c_bval(c_bval),
    .c_rd(c_rd), .c_wr(c_wr), .c_rdata(s_rdata), .c_ack(s_ack), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_bval(s_mem_bval), .mem_rd(s_mem_rd), .mem_wr(s_mem_wr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_cnt(s_hit), .miss_cnt(s_miss)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bval;
    logic [31:0] mdata;
    int          exp_nrd;
    int          exp_nwr;
    logic [31:0] exp_rdata;
    int          exp_hit;
    int          exp_miss;
    int          exp_lat;   // 0 = latency not checked
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One CPU transaction with a memory responder that acks 3 cycles after a request.
  task automatic do_op(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [31:0] wdata, input logic [3:0] bval,
                       input logic [31:0] mdata, output int n_rd, output int n_wr,
                       output int lat, output logic [15:0] maddr, output logic [3:0] mbval,
                       output logic [31:0] mwdata, output logic [31:0] rdata);
    logic busy, both, got;
    int   wcnt;
    n_rd = 0; n_wr = 0; lat = 0; maddr = '0; mbval = '0; mwdata = '0; rdata = '0;
    busy = 1'b0; both = 1'b0; got = 1'b0; wcnt = 0;
    @(negedge c_clk);
    c_rd = rd; c_wr = wr; c_addr = addr; c_wdata = wdata; c_bval = bval;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge c_clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
        busy = 1'b0;
      end
      if (c_ack) begin
        got = 1'b1;
        lat = i;
        rdata = c_rdata;
      end else if (mem_rd || mem_wr) begin
        if (mem_rd && mem_wr) both = 1'b1;
        if (!busy) begin
          busy = 1'b1;
          wcnt = 0;
          if (mem_rd) n_rd++;
          if (mem_wr) n_wr++;
          maddr = mem_addr; mbval = mem_bval; mwdata = mem_wdata;
        end
        wcnt++;
        if (wcnt == 3) begin
          mem_ack = 1'b1;
          mem_rdata = mdata;
        end
      end
    end
    chk("ack_timeout", {31'b0, got}, 32'd1);
    chk("mem_rd_wr_excl", {31'b0, both}, 32'd0);
    c_rd = 1'b0; c_wr = 1'b0;
    @(negedge c_clk);
    chk("ack_fall", {31'b0, c_ack}, 32'd0);
  endtask

  int          n_rd, n_wr, lat;
  logic [15:0] maddr;
  logic [3:0]  mbval;
  logic [31:0] mwdata, rdata;

  initial begin
    //        rd    wr    addr      wdata         bval   mdata         nrd nwr rdata        hit miss lat
    vecs[0]  = '{1'b1, 1'b0, 16'h0010, 32'h0,        4'h0, 32'hDEADBEEF, 1, 0, 32'hDEADBEEF, 0, 1, 0};
    vecs[1]  = '{1'b1, 1'b0, 16'h0010, 32'h0,        4'h0, 32'h0,        0, 0, 32'hDEADBEEF, 1, 1, 2};
    vecs[2]  = '{1'b0, 1'b1, 16'h0010, 32'h00001234, 4'h3, 32'h0,        0, 1, 32'hDEADBEEF, 1, 1, 0};
    vecs[3]  = '{1'b1, 1'b0, 16'h0010, 32'h0,        4'h0, 32'h0,        0, 0, 32'hDEAD1234, 2, 1, 2};
    vecs[4]  = '{1'b0, 1'b1, 16'h0040, 32'h11112222, 4'hF, 32'h0,        0, 1, 32'hDEAD1234, 2, 1, 0};
    vecs[5]  = '{1'b1, 1'b0, 16'h0040, 32'h0,        4'h0, 32'hCAFE0040, 1, 0, 32'hCAFE0040, 2, 2, 0};
    vecs[6]  = '{1'b1, 1'b0, 16'h0050, 32'h0,        4'h0, 32'hA5A50050, 1, 0, 32'hA5A50050, 2, 3, 0};
    vecs[7]  = '{1'b1, 1'b0, 16'h0010, 32'h0,        4'h0, 32'h0B0B0010, 1, 0, 32'h0B0B0010, 2, 4, 0};
    vecs[8]  = '{1'b0, 1'b1, 16'h0010, 32'hFFFFFFFF, 4'h0, 32'h0,        0, 0, 32'h0B0B0010, 2, 4, 2};
    vecs[9]  = '{1'b1, 1'b0, 16'h0010, 32'h0,        4'h0, 32'h0,        0, 0, 32'h0B0B0010, 3, 4, 2};
    vecs[10] = '{1'b1, 1'b1, 16'h0010, 32'hFFFFFFFF, 4'hF, 32'h0,        0, 0, 32'h0B0B0010, 4, 4, 2};
    vecs[11] = '{1'b1, 1'b0, 16'h0013, 32'h0,        4'h0, 32'h0,        0, 0, 32'h0B0B0010, 5, 4, 2};

    // Reset state
    repeat (2) @(negedge c_clk);
    chk("rst_c_ack", {31'b0, c_ack}, 32'd0);
    chk("rst_mem_rd_wr", {30'b0, mem_rd, mem_wr}, 32'd0);
    chk("rst_c_rdata", c_rdata, 32'h0);
    chk("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
    chk("rst_mem_wdata_bval", mem_wdata | {28'h0, mem_bval}, 32'h0);
    chk("rst_counters", {hit_cnt, miss_cnt}, 32'h0);
    nReset = 1'b1;
    @(negedge c_clk);

    // Vector table
    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].bval, vecs[i].mdata,
            n_rd, n_wr, lat, maddr, mbval, mwdata, rdata);
      chk($sformatf("v%0d_n_mem_rd", i), n_rd, vecs[i].exp_nrd);
      chk($sformatf("v%0d_n_mem_wr", i), n_wr, vecs[i].exp_nwr);
      if (vecs[i].exp_nrd + vecs[i].exp_nwr > 0) begin
        chk($sformatf("v%0d_mem_addr", i), {16'h0, maddr}, {16'h0, vecs[i].addr & 16'hFFFC});
        chk($sformatf("v%0d_mem_bval", i), {28'h0, mbval},
            {28'h0, (vecs[i].exp_nrd > 0) ? 4'hF : vecs[i].bval});
      end
      if (vecs[i].exp_nwr > 0) chk($sformatf("v%0d_mem_wdata", i), mwdata, vecs[i].wdata);
      chk($sformatf("v%0d_c_rdata", i), rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d_hit_cnt", i), {16'h0, hit_cnt}, vecs[i].exp_hit);
      chk($sformatf("v%0d_miss_cnt", i), {16'h0, miss_cnt}, vecs[i].exp_miss);
      if (vecs[i].exp_lat != 0) chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
    end

    // Hold c_rd high after ack: ack stays, no new request is taken
    begin
      int bad_ack, bad_mem, waited;
      logic got;
      bad_ack = 0; bad_mem = 0; got = 1'b0; waited = 0;
      @(negedge c_clk);
      c_rd = 1'b1; c_addr = 16'h0010;
      while (!got && waited < 10) begin
        @(negedge c_clk);
        waited++;
        got = c_ack;
      end
      chk("hold_ack_seen", {31'b0, got}, 32'd1);
      for (int k = 0; k < 10; k++) begin
        @(negedge c_clk);
        if (!c_ack) bad_ack++;
        if (mem_rd || mem_wr) bad_mem++;
      end
      chk("hold_ack_level", bad_ack, 0);
      chk("hold_no_mem_req", bad_mem, 0);
      chk("hold_hit_cnt", {16'h0, hit_cnt}, 32'd6);
      chk("hold_c_rdata", c_rdata, 32'h0B0B0010);
      c_rd = 1'b0;
      @(negedge c_clk);
      chk("hold_ack_fall", {31'b0, c_ack}, 32'd0);
    end

    // Reset asserted while a memory read is outstanding, then a stale ack
    begin
      logic seen;
      int   busy_after;
      seen = 1'b0; busy_after = 0;
      @(negedge c_clk);
      c_rd = 1'b1; c_addr = 16'h0020;
      for (int k = 0; k < 10 && !seen; k++) begin
        @(negedge c_clk);
        seen = mem_rd;
      end
      chk("rst_mid_mem_rd_seen", {31'b0, seen}, 32'd1);
      chk("rst_mid_mem_addr", {16'h0, mem_addr}, 32'h0020);
      nReset = 1'b0;
      #1;
      chk("rst_mid_mem_rd", {31'b0, mem_rd}, 32'd0);
      chk("rst_mid_mem_addr_clr", {16'h0, mem_addr}, 32'h0);
      chk("rst_mid_counters", {hit_cnt, miss_cnt}, 32'h0);
      chk("rst_mid_c_rdata", c_rdata, 32'h0);
      c_rd = 1'b0;
      @(negedge c_clk);
      nReset = 1'b1;
      @(negedge c_clk);
      mem_ack = 1'b1; mem_rdata = 32'h77777777;
      @(negedge c_clk);
      mem_ack = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(negedge c_clk);
        if (c_ack || mem_rd || mem_wr || c_rdata != 32'h0) busy_after++;
      end
      chk("stale_ack_ignored", busy_after, 0);
    end
    do_op(1'b1, 1'b0, 16'h0010, 32'h0, 4'h0, 32'h31313131, n_rd, n_wr, lat, maddr, mbval,
          mwdata, rdata);
    chk("post_rst_refetch", n_rd, 1);
    chk("post_rst_rdata", rdata, 32'h31313131);
    chk("post_rst_counts", {hit_cnt, miss_cnt}, {16'd0, 16'd1});
    do_op(1'b1, 1'b0, 16'h0020, 32'h0, 4'h0, 32'h20202020, n_rd, n_wr, lat, maddr, mbval,
          mwdata, rdata);
    chk("aborted_line_invalid", n_rd, 1);
    chk("aborted_line_rdata", rdata, 32'h20202020);

    // Saturation on the 2-bit twin: 4 hits and 4 misses since reset
    for (int k = 0; k < 4; k++) begin
      do_op(1'b1, 1'b0, 16'h0010, 32'h0, 4'h0, 32'h0, n_rd, n_wr, lat, maddr, mbval,
            mwdata, rdata);
      if (k == 2) chk("sat_hit_at_max", {30'b0, s_hit}, 32'd3);
    end
    chk("sat_hit_holds", {30'b0, s_hit}, 32'd3);
    chk("wide_hit_cnt", {16'h0, hit_cnt}, 32'd4);
    do_op(1'b1, 1'b0, 16'h0080, 32'h0, 4'h0, 32'h80808080, n_rd, n_wr, lat, maddr, mbval,
          mwdata, rdata);
    chk("sat_miss_at_max", {30'b0, s_miss}, 32'd3);
    do_op(1'b1, 1'b0, 16'h00C0, 32'h0, 4'h0, 32'hC0C0C0C0, n_rd, n_wr, lat, maddr, mbval,
          mwdata, rdata);
    chk("sat_miss_holds", {30'b0, s_miss}, 32'd3);
    chk("wide_miss_cnt", {16'h0, miss_cnt}, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
